// File: rtl/spg_pkg.sv
// Shared types, default widths and saturating sample arithmetic for the test-pulse DAC source.
// The sample datapath is sized by DW_DEF; the top-level DW parameter must match it.
package spg_pkg;

  localparam int DW_DEF = 14;
  localparam int CW_DEF = 32;
  localparam int NW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP,
    RISE
  } spg_state_t;

  typedef logic [DW_DEF-1:0] sample_t;

  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic [DW_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DW_DEF] ? '1 : sum[DW_DEF-1:0];
  endfunction

  function automatic sample_t sat_sub(input sample_t a, input sample_t b);
    return (b > a) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/spg_level_calc.sv
// Combinational pulse level: baseline moved by amplitude in the polarity direction,
// clamped to the DAC code range.
module spg_level_calc
  import spg_pkg::*;
(
  input  sample_t base,
  input  sample_t amp,
  input  logic    pol,
  output sample_t level
);

  assign level = pol ? sat_add(base, amp) : sat_sub(base, amp);

endmodule

// File: rtl/single_pulse_dac_gen.sv
// Programmable rectangular test-pulse source for the DAC path on adc_clk.
// Optional rising-edge ramp is enabled by defining SPG_RISE_RAMP_EN.
module single_pulse_dac_gen
  import spg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          adc_clk,
  input  logic          adc_rst,
  input  logic          enable,
  input  logic          start,
  input  logic [DW-1:0] baseline,
  input  logic [DW-1:0] amplitude,
  input  logic          polarity,
  input  logic [CW-1:0] pulse_width,
  input  logic [CW-1:0] period,
  input  logic [NW-1:0] pulse_count,
`ifdef SPG_RISE_RAMP_EN
  input  logic [DW-1:0] rise_step,
`endif
  output logic [DW-1:0] dac_dat,
  output logic          pulse_active,
  output logic          sync_out,
  output logic          busy,
  output logic          done
);

  spg_state_t    state_q, state_d;
  spg_state_t    entry_live, entry_lat;
  logic [DW-1:0] level_c, level_q, base_q;
  logic [CW-1:0] width_q, gap_q, cnt_q, gap_c;
  logic [NW-1:0] count_q, pulses_q;
  logic          finish_q, finish_d;
  logic          start_ok, pulse_q, pulse_d;
  logic [DW-1:0] dac_c;
  logic          active_c, sync_c, busy_c, done_c;

  spg_level_calc u_level (
    .base (baseline),
    .amp  (amplitude),
    .pol  (polarity),
    .level(level_c)
  );

  assign gap_c    = (period > pulse_width) ? (period - pulse_width) : CW'(1);
  assign start_ok = start && enable && (pulse_width != '0);
  assign pulse_q  = (state_q == HIGH) || (state_q == RISE);
  assign pulse_d  = (state_d == HIGH) || (state_d == RISE);

`ifdef SPG_RISE_RAMP_EN
  logic [DW-1:0] step_q, ramp_q, ramp_raw, ramp_step;
  logic          pol_q;

  // Each ramp step reuses the saturating level math, then clamps so it lands exactly on L.
  spg_level_calc u_ramp (
    .base (ramp_q),
    .amp  (step_q),
    .pol  (pol_q),
    .level(ramp_raw)
  );

  assign ramp_step  = pol_q ? ((ramp_raw > level_q) ? level_q : ramp_raw)
                            : ((ramp_raw < level_q) ? level_q : ramp_raw);
  assign entry_live = (rise_step != '0) ? RISE : HIGH;
  assign entry_lat  = (step_q != '0) ? RISE : HIGH;

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      step_q <= '0;
      ramp_q <= '0;
      pol_q  <= 1'b0;
    end else if (state_q == IDLE && state_d != IDLE) begin
      step_q <= rise_step;
      ramp_q <= baseline;
      pol_q  <= polarity;
    end else if (state_q == GAP && pulse_d) begin
      ramp_q <= base_q;
    end else if (state_q == RISE) begin
      ramp_q <= ramp_step;
    end
  end
`else
  assign entry_live = HIGH;
  assign entry_lat  = HIGH;
`endif

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
      cnt_q    <= '0;
      pulses_q <= '0;
      level_q  <= '0;
      base_q   <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_d;
      // cnt_q counts cycles within the current pulse (RISE+HIGH together) or gap.
      if (state_d == IDLE) cnt_q <= '0;
      else if (pulse_d != pulse_q) cnt_q <= CW'(1);
      else cnt_q <= cnt_q + CW'(1);
      if (state_q == IDLE && state_d != IDLE) begin
        level_q  <= level_c;
        base_q   <= baseline;
        width_q  <= pulse_width;
        gap_q    <= gap_c;
        count_q  <= pulse_count;
        pulses_q <= NW'(1);
      end else if (state_q == GAP && pulse_d && pulses_q != '1) begin
        pulses_q <= pulses_q + NW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    finish_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_ok) state_d = entry_live;
        HIGH: if (cnt_q == width_q) state_d = GAP;
`ifdef SPG_RISE_RAMP_EN
        RISE: begin
          if (cnt_q == width_q) state_d = GAP;
          else if (ramp_step == level_q) state_d = HIGH;
        end
`endif
        GAP: begin
          if (cnt_q == gap_q) begin
            if (count_q != '0 && pulses_q == count_q) begin
              state_d  = IDLE;
              finish_d = 1'b1;
            end else begin
              state_d = entry_lat;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle.
  always_comb begin
    dac_c    = baseline;
    active_c = 1'b0;
    sync_c   = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: done_c = finish_q;
        HIGH: begin
          dac_c    = level_q;
          active_c = 1'b1;
          sync_c   = (cnt_q == CW'(1));
          busy_c   = 1'b1;
        end
`ifdef SPG_RISE_RAMP_EN
        RISE: begin
          dac_c    = ramp_step;
          active_c = 1'b1;
          sync_c   = (cnt_q == CW'(1));
          busy_c   = 1'b1;
        end
`endif
        GAP: begin
          dac_c  = base_q;
          busy_c = 1'b1;
        end
        default: dac_c = baseline;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      dac_dat      <= '0;
      pulse_active <= 1'b0;
      sync_out     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dac_dat      <= dac_c;
      pulse_active <= active_c;
      sync_out     <= sync_c;
      busy         <= busy_c;
      done         <= done_c;
    end
  end

endmodule

// File: tb/tb_single_pulse_dac_gen.sv
// Directed bench for single_pulse_dac_gen: table of finite bursts plus hand-written
// sequences for abort, ignored starts, latching, reset and (with SPG_RISE_RAMP_EN) the ramp.
module tb_single_pulse_dac_gen;

  logic        adc_clk;
  logic        adc_rst;
  logic        enable;
  logic        start;
  logic [13:0] baseline;
  logic [13:0] amplitude;
  logic        polarity;
  logic [31:0] pulse_width;
  logic [31:0] period;
  logic [15:0] pulse_count;
`ifdef SPG_RISE_RAMP_EN
  logic [13:0] rise_step;
`endif
  logic [13:0] dac_dat;
  logic        pulse_active;
  logic        sync_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int base;
    int amp;
    int pol;
    int width;
    int period;
    int count;
    int exp_level;
    int exp_gap;
  } burst_vec_t;

  burst_vec_t vecs[6];

  single_pulse_dac_gen dut (
    .adc_clk     (adc_clk),
    .adc_rst     (adc_rst),
    .enable      (enable),
    .start       (start),
    .baseline    (baseline),
    .amplitude   (amplitude),
    .polarity    (polarity),
    .pulse_width (pulse_width),
    .period      (period),
    .pulse_count (pulse_count),
`ifdef SPG_RISE_RAMP_EN
    .rise_step   (rise_step),
`endif
    .dac_dat     (dac_dat),
    .pulse_active(pulse_active),
    .sync_out    (sync_out),
    .busy        (busy),
    .done        (done)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  // Advance one rising edge and land on the following falling edge, where we drive and sample.
  task automatic tick();
    @(posedge adc_clk);
    @(negedge adc_clk);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input burst_vec_t v);
    baseline    = 14'(v.base);
    amplitude   = 14'(v.amp);
    polarity    = v.pol[0];
    pulse_width = 32'(v.width);
    period      = 32'(v.period);
    pulse_count = 16'(v.count);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic check_burst(input int idx, input burst_vec_t v);
    int len;
    int pos;
    bit in_pulse;
    len = v.width + v.exp_gap;
    apply_stimulus(v);
    for (int k = 0; k < v.count * len; k++) begin
      tick();
      pos      = k % len;
      in_pulse = (pos < v.width);
      check_output($sformatf("v%0d dac c%0d", idx, k + 1), int'(dac_dat), in_pulse ? v.exp_level : v.base);
      check_output($sformatf("v%0d sync c%0d", idx, k + 1), int'(sync_out), (pos == 0) ? 1 : 0);
      check_output($sformatf("v%0d active c%0d", idx, k + 1), int'(pulse_active), in_pulse ? 1 : 0);
      check_output($sformatf("v%0d busy c%0d", idx, k + 1), int'(busy), 1);
      check_output($sformatf("v%0d done c%0d", idx, k + 1), int'(done), 0);
    end
    tick();
    check_output($sformatf("v%0d done strobe", idx), int'(done), 1);
    check_output($sformatf("v%0d busy at done", idx), int'(busy), 0);
    check_output($sformatf("v%0d dac at done", idx), int'(dac_dat), v.base);
    tick();
    check_output($sformatf("v%0d done cleared", idx), int'(done), 0);
  endtask

  initial begin
    vecs[0] = '{base: 8192,  amp: 1000,  pol: 1, width: 4, period: 10, count: 3, exp_level: 9192,  exp_gap: 6};
    vecs[1] = '{base: 500,   amp: 1000,  pol: 0, width: 2, period: 4,  count: 1, exp_level: 0,     exp_gap: 2};
    vecs[2] = '{base: 16000, amp: 1000,  pol: 1, width: 3, period: 5,  count: 1, exp_level: 16383, exp_gap: 2};
    vecs[3] = '{base: 5,     amp: 7,     pol: 1, width: 5, period: 3,  count: 2, exp_level: 12,    exp_gap: 1};
    vecs[4] = '{base: 3000,  amp: 3000,  pol: 0, width: 1, period: 2,  count: 2, exp_level: 0,     exp_gap: 1};
    vecs[5] = '{base: 0,     amp: 16383, pol: 1, width: 1, period: 1,  count: 1, exp_level: 16383, exp_gap: 1};

    adc_rst     = 1'b1;
    enable      = 1'b1;
    start       = 1'b0;
    baseline    = 14'd1234;
    amplitude   = '0;
    polarity    = 1'b1;
    pulse_width = '0;
    period      = '0;
    pulse_count = '0;
`ifdef SPG_RISE_RAMP_EN
    rise_step   = '0;
`endif
    @(negedge adc_clk);
    tick();
    tick();
    check_output("reset dac", int'(dac_dat), 0);
    check_output("reset active", int'(pulse_active), 0);
    check_output("reset sync", int'(sync_out), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    adc_rst = 1'b0;
    tick();
    check_output("idle live baseline", int'(dac_dat), 1234);

    for (int i = 0; i < 6; i++) begin
      check_burst(i, vecs[i]);
      tick();
    end

    // Infinite burst: ignored restart, latched level, then abort by enable.
    baseline = 14'd1000; amplitude = 14'd50; polarity = 1'b1;
    pulse_width = 32'd3; period = 32'd6; pulse_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("inf first dac", int'(dac_dat), 1050);
    check_output("inf first sync", int'(sync_out), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("inf restart no sync", int'(sync_out), 0);
    check_output("inf restart dac", int'(dac_dat), 1050);
    amplitude = 14'd2000;
    tick();
    check_output("inf third high", int'(dac_dat), 1050);
    tick();
    check_output("inf gap dac", int'(dac_dat), 1000);
    check_output("inf gap active", int'(pulse_active), 0);
    tick();
    tick();
    check_output("inf gap end busy", int'(busy), 1);
    tick();
    check_output("inf latched level", int'(dac_dat), 1050);
    check_output("inf second sync", int'(sync_out), 1);
    enable = 1'b0;
    tick();
    check_output("abort dac", int'(dac_dat), 1000);
    check_output("abort busy", int'(busy), 0);
    check_output("abort active", int'(pulse_active), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output($sformatf("abort no done %0d", k), int'(done), 0);
      check_output($sformatf("abort idle busy %0d", k), int'(busy), 0);
    end

    // Start while disabled, and start with zero width, are both ignored.
    amplitude = 14'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("start while disabled busy", int'(busy), 0);
    enable = 1'b1;
    pulse_width = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("zero width busy", int'(busy), 0);
    tick();
    check_output("zero width dac", int'(dac_dat), 1000);

    // Reset in the middle of a pulse.
    baseline = 14'd200; amplitude = 14'd100; pulse_width = 32'd5; period = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("pre-reset dac", int'(dac_dat), 300);
    adc_rst = 1'b1;
    tick();
    check_output("mid reset dac", int'(dac_dat), 0);
    check_output("mid reset active", int'(pulse_active), 0);
    check_output("mid reset sync", int'(sync_out), 0);
    check_output("mid reset busy", int'(busy), 0);
    check_output("mid reset done", int'(done), 0);
    adc_rst = 1'b0;
    tick();
    check_output("post reset idle dac", int'(dac_dat), 200);
    check_output("post reset busy", int'(busy), 0);

`ifdef SPG_RISE_RAMP_EN
    begin
      int ramp_exp[8] = '{30, 60, 90, 100, 100, 100, 100, 100};
      baseline = 14'd0; amplitude = 14'd100; polarity = 1'b1; rise_step = 14'd30;
      pulse_width = 32'd8; period = 32'd12; pulse_count = 16'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        check_output($sformatf("ramp dac c%0d", k + 1), int'(dac_dat), ramp_exp[k]);
        check_output($sformatf("ramp sync c%0d", k + 1), int'(sync_out), (k == 0) ? 1 : 0);
        check_output($sformatf("ramp active c%0d", k + 1), int'(pulse_active), 1);
      end
      tick();
      check_output("ramp gap dac", int'(dac_dat), 0);
      for (int k = 0; k < 4; k++) tick();
      check_output("ramp done", int'(done), 1);
      rise_step = '0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_pulse_dac_gen.md
Name: single_pulse_dac_gen

Overview:
- Programmable rectangular test-pulse source driving the 14-bit DAC path on the ADC clock domain.
- Produces pulses of set amplitude, width, period and polarity about a baseline, for loopback into the threshold-trigger logic on the ADC side.
- Supports one-shot and burst/continuous operation, with a single-cycle sync marker at each pulse start.

Parameters:
- DW, 14, DAC sample width (unsigned).
- CW, 32, width of the pulse-width and period counters.
- NW, 16, width of the burst pulse counter.

Ports:
- adc_clk  in  1  system clock; all logic on its rising edge.
- adc_rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 0 aborts any activity and holds the output at baseline.
- start  in  1  one-cycle strobe; begins a burst when IDLE.
- baseline  in  DW  idle output level.
- amplitude  in  DW  pulse height relative to baseline.
- polarity  in  1  1 = pulse above baseline, 0 = pulse below baseline.
- pulse_width  in  CW  cycles at pulse level; 0 = start ignored.
- period  in  CW  cycles from one pulse start to the next.
- pulse_count  in  NW  pulses per burst; 0 = run until enable drops.
- dac_dat  out  DW  registered DAC sample.
- pulse_active  out  1  high while dac_dat is at (or ramping to) pulse level.
- sync_out  out  1  one-cycle strobe coincident with the first pulse-level sample of each pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle strobe when a finite burst completes.

Behaviour:
- Reset: dac_dat = 0, pulse_active = 0, sync_out = 0, busy = 0, done = 0; FSM to IDLE; counters cleared.
- Pulse level L is computed at start:
  - polarity = 1: L = baseline + amplitude, saturating at 2^DW-1.
  - polarity = 0: L = baseline - amplitude, saturating at 0.
- Latching: L, pulse_width, period, pulse_count and polarity are captured at start. Later input changes do not affect a running burst. baseline is also latched.
- FSM states: IDLE, HIGH, GAP.
  - IDLE: dac_dat = baseline (live value).
    - start && enable && pulse_width != 0 -> HIGH.
    - start is ignored otherwise, or when not in IDLE.
  - HIGH: dac_dat = L, pulse_active = 1. sync_out = 1 on the first HIGH cycle only. Stays exactly pulse_width cycles, then -> GAP.
  - GAP: dac_dat = baseline. Stays max(period - pulse_width, 1) cycles. Then:
    - if pulse_count != 0 and pulses emitted == pulse_count -> IDLE with done = 1 for one cycle;
    - otherwise -> HIGH.
- Latency: start sampled at edge N; dac_dat = L, sync_out = 1 and busy = 1 are visible after edge N+1.
- period <= pulse_width: GAP is forced to 1 cycle, so baseline appears for 1 cycle between pulses.
- enable low in any state: next cycle FSM -> IDLE, dac_dat = baseline, pulse_active = 0, no done strobe.
- start coincident with enable falling: ignored.
- Counters compare by equality against latched values. No wrap is possible within a burst. The burst counter saturates at 2^NW-1 in infinite mode.

Optional Feature:
- Macro: SPG_RISE_RAMP_EN.
- With the macro:
  - Adds input rise_step [DW-1:0] and a RISE state between IDLE/GAP and HIGH.
  - RISE steps dac_dat from baseline toward L by rise_step per cycle, saturating exactly at L. pulse_active = 1 and sync_out fires on the first RISE cycle.
  - RISE cycles count toward pulse_width; if pulse_width expires during RISE, go directly -> GAP.
  - rise_step = 0 is treated as an instant edge (RISE skipped).
- Without the macro: no rise_step port and no RISE state; edges are instantaneous.

Decomposition:
- Package spg_pkg:
  - state enum (IDLE, HIGH, GAP, RISE);
  - DW/CW/NW default constants;
  - saturating add/sub functions.
- Sub-module spg_level_calc: combinational saturating level computation (baseline, amplitude, polarity -> L). Reused by the ramp path for per-step saturation.

Test Plan:
- baseline=8192, amplitude=1000, polarity=1, width=4, period=10, count=3, start -> three pulses:
  - dac_dat=9192 for 4 cycles, then 8192 for 6 cycles;
  - sync_out at cycles 1, 11, 21 after start;
  - done 1 cycle after the third gap;
  - busy drops with done.
- baseline=500, amplitude=1000, polarity=0 -> L saturates to 0. Repeat with baseline=16000, amplitude=1000, polarity=1 -> L = 16383.
- width=5, period=3, count=2 -> gap forced to 1 cycle; pattern is 5 cycles L, 1 baseline, 5 L, 1 baseline, then done.
- count=0 (infinite), enable dropped mid-HIGH -> next cycle dac_dat = baseline, busy = 0, no done. A new start while running is ignored. width=0 start leaves busy = 0.
- amplitude changed during a burst -> subsequent pulses keep the latched L. Reset asserted mid-HIGH -> next cycle dac_dat = 0 and all flags 0.
- SPG_RISE_RAMP_EN: baseline=0, amplitude=100, rise_step=30, width=8 -> dac_dat sequence 30, 60, 90, 100, 100, 100, 100, 100, then 0.
